// File: rtl/instr_loader_pkg.sv
// rtl/instr_loader_pkg.sv - shared types and constants for the program loader
// Contents:
//   state_t    : loader FSM states
//   WORD_BYTES : bytes per instruction word
//   HDR_BYTES  : bytes in the little-endian word-count header
package instr_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_LOAD  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERROR = 3'd5
  } state_t;

  localparam int WORD_BYTES = 4;
  localparam int HDR_BYTES  = 2;

endpackage

// File: rtl/instr_loader_if.sv
// rtl/instr_loader_if.sv - host byte stream and instruction-memory write bundle
// Signals:
//   byte_valid/byte_data/byte_ready : host byte handshake
//   mem_write/mem_addr/mem_data     : synchronous memory write port
// Modports:
//   master : the loader (consumes bytes, drives the memory write)
//   slave  : host link plus instruction memory
interface instr_loader_if;

  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;

  modport master (
    input  byte_valid,
    input  byte_data,
    output byte_ready,
    output mem_write,
    output mem_addr,
    output mem_data
  );

  modport slave (
    output byte_valid,
    output byte_data,
    input  byte_ready,
    input  mem_write,
    input  mem_addr,
    input  mem_data
  );

endinterface

// File: rtl/instr_loader_byte_packer.sv
// rtl/instr_loader_byte_packer.sv - little-endian byte-to-word packer
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   clear      : restart packing at byte 0
//   in_valid   : a byte is accepted this cycle
//   in_data    : the accepted byte
//   word_next  : current word with in_data inserted at the current byte slot
//   word_full  : the accepted byte completes the word
module byte_packer
  import instr_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic [31:0] word_next,
  output logic        word_full
);

  logic [31:0] word;
  logic [1:0]  byte_idx;

  always_comb begin
    word_next = word;
    word_next[8*byte_idx +: 8] = in_data;
    word_full = in_valid && (byte_idx == 2'(WORD_BYTES - 1));
  end

  // The counter wraps 3 -> 0 on its own, so the next word starts at the LSB.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      word     <= '0;
      byte_idx <= '0;
    end else if (in_valid) begin
      word     <= word_next;
      byte_idx <= byte_idx + 2'd1;
    end
  end

endmodule

// File: rtl/instr_loader.sv
// rtl/instr_loader.sv - fills instruction memory from a host byte stream
// Parameters:
//   DEPTH     : instruction memory size in words (max loadable count)
//   BASE_ADDR : byte address of the first word, 4-byte aligned
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   start     : begins a load from IDLE, DONE or ERROR
//   bus       : byte handshake in, memory write out
//   busy      : load in progress, core stalls
//   done      : sticky, load completed
//   error     : sticky, header count exceeded DEPTH
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int          DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  instr_loader_if.master bus,
  output logic         busy,
  output logic         done,
  output logic         error
);

  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  state_t      state;
  logic        hdr_cnt;
  logic [7:0]  hdr_lo;
  logic [15:0] n_words;
  logic [15:0] idx;
  logic [15:0] idx_next;
  logic [15:0] hdr_n;
  logic        fire;
  logic        load_fire;
  logic        start_take;
  logic [31:0] word_next;
  logic        word_full;

  assign fire       = bus.byte_valid && bus.byte_ready;
  assign load_fire  = fire && (state == ST_LOAD);
  assign start_take = start &&
                      ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERROR));
  assign idx_next   = idx + 16'd1;
  assign hdr_n      = {bus.byte_data, hdr_lo};

  byte_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (start_take),
    .in_valid  (load_fire),
    .in_data   (bus.byte_data),
    .word_next (word_next),
    .word_full (word_full)
  );

  // byte_ready is registered, so every transition sets it for the state
  // being entered; this keeps it low in the WRITE cycle after the 4th byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      bus.byte_ready <= 1'b0;
      bus.mem_write  <= 1'b0;
      bus.mem_addr   <= BASE_ADDR;
      bus.mem_data   <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      hdr_cnt        <= 1'b0;
      hdr_lo         <= '0;
      n_words        <= '0;
      idx            <= '0;
    end else begin
      bus.mem_write <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            state          <= ST_HDR;
            bus.byte_ready <= 1'b1;
            bus.mem_addr   <= BASE_ADDR;
            busy           <= 1'b1;
            done           <= 1'b0;
            error          <= 1'b0;
            hdr_cnt        <= 1'b0;
            idx            <= '0;
          end
        end

        ST_HDR: begin
          if (fire) begin
            if (hdr_cnt != 1'(HDR_BYTES - 1)) begin
              hdr_lo  <= bus.byte_data;
              hdr_cnt <= 1'b1;
            end else begin
              n_words <= hdr_n;
              if (hdr_n == 16'd0) begin
                state          <= ST_DONE;
                bus.byte_ready <= 1'b0;
                busy           <= 1'b0;
                done           <= 1'b1;
              end else if ({1'b0, hdr_n} > DEPTH_W) begin
                state          <= ST_ERROR;
                bus.byte_ready <= 1'b0;
                busy           <= 1'b0;
                error          <= 1'b1;
              end else begin
                state <= ST_LOAD;
              end
            end
          end
        end

        ST_LOAD: begin
          if (word_full) begin
            state          <= ST_WRITE;
            bus.byte_ready <= 1'b0;
            bus.mem_write  <= 1'b1;
            bus.mem_data   <= word_next;
          end
        end

        ST_WRITE: begin
          idx          <= idx_next;
          bus.mem_addr <= bus.mem_addr + 32'd4;
          if (idx_next == n_words) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state          <= ST_LOAD;
            bus.byte_ready <= 1'b1;
          end
        end

        default: begin
          state          <= ST_IDLE;
          bus.byte_ready <= 1'b0;
          busy           <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// tb/tb_instr_loader.sv - scoreboard bench for instr_loader
module tb_instr_loader;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk;
  logic        rst;
  logic        st;
  logic        bv;
  logic [7:0]  bd;
  int          sel;
  logic        gap;
  logic        busy0, done0, error0;
  logic        busy1, done1, error1;

  int vectors;
  int miscompares;

  wr_t q0[$];
  wr_t q1[$];
  wr_t e0, e1;

  instr_loader_if if0();
  instr_loader_if if1();

  assign if0.byte_valid = bv && (sel == 0);
  assign if0.byte_data  = bd;
  assign if1.byte_valid = bv && (sel == 1);
  assign if1.byte_data  = bd;

  instr_loader #(.DEPTH(256), .BASE_ADDR(32'h0000_0000)) dut0 (
    .clk   (clk),
    .rst   (rst),
    .start (st && (sel == 0)),
    .bus   (if0.master),
    .busy  (busy0),
    .done  (done0),
    .error (error0)
  );

  instr_loader #(.DEPTH(256), .BASE_ADDR(32'h0000_0100)) dut1 (
    .clk   (clk),
    .rst   (rst),
    .start (st && (sel == 1)),
    .bus   (if1.master),
    .busy  (busy1),
    .done  (done1),
    .error (error1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic r_ready();  return sel == 0 ? if0.byte_ready : if1.byte_ready; endfunction
  function automatic logic r_write();  return sel == 0 ? if0.mem_write  : if1.mem_write;  endfunction
  function automatic logic r_busy();   return sel == 0 ? busy0  : busy1;  endfunction
  function automatic logic r_done();   return sel == 0 ? done0  : done1;  endfunction
  function automatic logic r_error();  return sel == 0 ? error0 : error1; endfunction
  function automatic logic [31:0] r_addr(); return sel == 0 ? if0.mem_addr : if1.mem_addr; endfunction

  // Write-port monitors: every strobe must match the next expected write.
  always @(negedge clk) begin
    if (if0.mem_write) begin
      if (q0.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write0: got addr %h data %h, expected no write", if0.mem_addr, if0.mem_data);
      end else begin
        e0 = q0.pop_front();
        chk("write0_addr", if0.mem_addr, e0.addr);
        chk("write0_data", if0.mem_data, e0.data);
        chk("write0_ready_low", {31'd0, if0.byte_ready}, 32'd0);
      end
    end
    if (if1.mem_write) begin
      if (q1.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write1: got addr %h data %h, expected no write", if1.mem_addr, if1.mem_data);
      end else begin
        e1 = q1.pop_front();
        chk("write1_addr", if1.mem_addr, e1.addr);
        chk("write1_data", if1.mem_data, e1.data);
        chk("write1_ready_low", {31'd0, if1.byte_ready}, 32'd0);
      end
    end
  end

  // Called at a negedge; returns at the negedge right after the handshake edge.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n  = 0;
    bv = 1'b1;
    bd = b;
    while (!r_ready() && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      vectors++;
      miscompares++;
      $display("FAIL byte_timeout: got byte_ready 0 for 50 cycles, expected 1");
      bv = 1'b0;
    end else begin
      @(posedge clk);
      @(negedge clk);
      bv = 1'b0;
    end
  endtask

  task automatic pulse_start();
    st = 1'b1;
    @(negedge clk);
    st = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input logic [31:0] addr);
    wr_t e;
    e.addr = addr;
    e.data = w;
    if (sel == 0) q0.push_back(e); else q1.push_back(e);
    for (int k = 0; k < 4; k++) begin
      if (gap) @(negedge clk);
      send_byte(w[8*k +: 8]);
    end
    chk("write_pulse_latency", {31'd0, r_write()}, 32'd1);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1; st = 1'b0; bv = 1'b0; bd = 8'h00; sel = 0; gap = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_ready", {31'd0, if0.byte_ready}, 32'd0);
    chk("rst_write", {31'd0, if0.mem_write}, 32'd0);
    chk("rst_addr0", if0.mem_addr, 32'h0);
    chk("rst_data", if0.mem_data, 32'h0);
    chk("rst_busy", {31'd0, busy0}, 32'd0);
    chk("rst_done", {31'd0, done0}, 32'd0);
    chk("rst_error", {31'd0, error0}, 32'd0);
    chk("rst_addr1", if1.mem_addr, 32'h100);

    // Single word
    pulse_start();
    chk("hdr_busy", {31'd0, r_busy()}, 32'd1);
    chk("hdr_ready", {31'd0, r_ready()}, 32'd1);
    send_byte(8'h01); send_byte(8'h00);
    send_word(32'h00A00513, 32'h0);
    @(negedge clk);
    chk("single_done", {31'd0, r_done()}, 32'd1);
    chk("single_busy", {31'd0, r_busy()}, 32'd0);

    // Three words with byte_valid toggling
    pulse_start();
    chk("three_done_cleared", {31'd0, r_done()}, 32'd0);
    gap = 1'b1;
    send_byte(8'h03); @(negedge clk); send_byte(8'h00);
    send_word(32'h00000093, 32'h0);
    send_word(32'h00108113, 32'h4);
    send_word(32'hFFF10193, 32'h8);
    gap = 1'b0;
    @(negedge clk);
    chk("three_done", {31'd0, r_done()}, 32'd1);
    chk("three_addr_after", r_addr(), 32'hC);

    // Zero-length header
    pulse_start();
    send_byte(8'h00); send_byte(8'h00);
    chk("zero_done", {31'd0, r_done()}, 32'd1);
    chk("zero_busy", {31'd0, r_busy()}, 32'd0);
    chk("zero_ready", {31'd0, r_ready()}, 32'd0);

    // Oversized header
    pulse_start();
    send_byte(8'h01); send_byte(8'h01);
    chk("err_flag", {31'd0, r_error()}, 32'd1);
    chk("err_busy", {31'd0, r_busy()}, 32'd0);
    chk("err_ready", {31'd0, r_ready()}, 32'd0);
    bv = 1'b1; bd = 8'hAA;
    repeat (4) @(negedge clk);
    chk("err_ready_held", {31'd0, r_ready()}, 32'd0);
    bv = 1'b0;
    chk("err_sticky", {31'd0, r_error()}, 32'd1);
    pulse_start();
    chk("err_cleared", {31'd0, r_error()}, 32'd0);
    send_byte(8'h01); send_byte(8'h00);
    send_word(32'h12345678, 32'h0);
    @(negedge clk);
    chk("err_reload_done", {31'd0, r_done()}, 32'd1);

    // Reset in the middle of word 1
    pulse_start();
    send_byte(8'h02); send_byte(8'h00);
    send_word(32'hCAFEF00D, 32'h0);
    send_byte(8'h11); send_byte(8'h22);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_ready", {31'd0, r_ready()}, 32'd0);
    chk("midrst_busy", {31'd0, r_busy()}, 32'd0);
    chk("midrst_done", {31'd0, r_done()}, 32'd0);
    chk("midrst_addr", r_addr(), 32'h0);
    chk("midrst_data", if0.mem_data, 32'h0);
    bv = 1'b1; bd = 8'h33;
    repeat (4) @(negedge clk);
    bv = 1'b0;
    chk("midrst_idle_ready", {31'd0, r_ready()}, 32'd0);
    pulse_start();
    send_byte(8'h01); send_byte(8'h00);
    send_word(32'hDEADBEEF, 32'h0);
    @(negedge clk);
    chk("midrst_reload_done", {31'd0, r_done()}, 32'd1);

    // start during LOAD on the BASE_ADDR=0x100 instance
    sel = 1;
    pulse_start();
    send_byte(8'h01); send_byte(8'h00);
    begin
      wr_t e;
      e.addr = 32'h100;
      e.data = 32'h44332211;
      q1.push_back(e);
    end
    send_byte(8'h11); send_byte(8'h22);
    pulse_start();
    chk("midstart_busy", {31'd0, r_busy()}, 32'd1);
    send_byte(8'h33); send_byte(8'h44);
    chk("midstart_pulse", {31'd0, r_write()}, 32'd1);
    @(negedge clk);
    chk("midstart_done", {31'd0, r_done()}, 32'd1);
    chk("midstart_addr_after", r_addr(), 32'h104);

    repeat (3) @(negedge clk);
    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Program loader that fills the instruction memory before the core runs, acting as the writer of the memory's synchronous write port (write / addr / inst_input).
- Takes a byte stream from a host link (UART RX or testbench) through a valid/ready handshake.
- Assembles little-endian 32-bit words and issues one memory write per word at consecutive word addresses.
- Holds the core in stall via `busy` until the whole program is written.

Parameters:
- DEPTH, 256, number of 32-bit words in the instruction memory; the maximum loadable word count.
- BASE_ADDR, 32'h0000_0000, byte address of the first word written; must be 4-byte aligned.

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERROR.
- byte_valid  input  1  host byte available.
- byte_data  input  8  host byte.
- byte_ready  output  1  loader accepts byte_data this cycle.
- mem_write  output  1  write strobe to the instruction memory, one-cycle pulse per word.
- mem_addr  output  32  byte address for the write; always word-aligned.
- mem_data  output  32  assembled instruction word.
- busy  output  1  load in progress; the core must stall while high.
- done  output  1  load completed successfully; sticky.
- error  output  1  header word count exceeded DEPTH; sticky.

Behaviour:
- Byte transfer happens when byte_valid && byte_ready in the same cycle; no other byte is consumed.
- Reset values: byte_ready=0, mem_write=0, mem_addr=BASE_ADDR, mem_data=0, busy=0, done=0, error=0, state=IDLE, word index=0, byte index=0.
- IDLE: byte_ready=0. On start, go to HDR and clear done and error.
- HDR: byte_ready=1, busy=1.
  - Accepts two bytes forming a 16-bit word count N, little-endian (first byte is N[7:0]).
  - After the second byte: if N==0, go to DONE. If N>DEPTH, go to ERROR. Otherwise go to LOAD.
- LOAD: byte_ready=1, busy=1.
  - Byte k (0..3) of the current word goes to mem_data[8k+7:8k]; the first byte received is the LSB.
  - After byte 3, go to WRITE. Nothing is written to memory while in LOAD.
- WRITE: exactly one cycle, byte_ready=0, busy=1.
  - mem_write=1, mem_addr=BASE_ADDR+4*idx, mem_data=the assembled word.
  - Latency: the write pulse occurs in the cycle immediately after the 4th byte handshake.
  - Next cycle: idx increments and mem_addr advances by 4. If idx+1==N, go to DONE, otherwise return to LOAD.
- DONE: busy=0, done=1, byte_ready=0. Remains here until start (go to HDR) or rst.
- ERROR: busy=0, error=1, byte_ready=0, no writes. Leaves only on start (go to HDR) or rst.
- mem_write is 0 in every state except WRITE.
- mem_addr and mem_data stay stable outside WRITE; mem_data holds the last assembled word.
- idx wraps never: N≤DEPTH guarantees idx<DEPTH.
- byte_valid stalls: if byte_valid is low in HDR or LOAD, the state and byte index hold indefinitely. No timeout.
- start while busy is ignored.
- start and rst asserted together: rst wins.
- rst mid-load (any state): next cycle is IDLE with reset values. The partial word is discarded, and words already written stay in memory.
- Bytes presented in IDLE, WRITE, DONE or ERROR are not accepted; byte_ready=0 in those states.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, HDR, LOAD, WRITE, DONE, ERROR);
  - the WORD_BYTES=4 constant;
  - the HDR_BYTES=2 constant.
- One natural sub-module, `byte_packer`: shift/insert of bytes into a 32-bit little-endian word, with a 2-bit byte counter and a `word_full` flag.
- The FSM, address counter and header capture stay in `instr_loader`.

Test Plan:
- Single word: start, header 01 00, bytes 13 05 A0 00 → one mem_write pulse with mem_addr=0x0, mem_data=0x00A00513, one cycle after the 4th byte; then done=1, busy=0.
- Three words, byte_valid toggling every other cycle → writes at 0x0, 0x4, 0x8 with correct words; exactly 3 mem_write pulses; byte_ready low during each WRITE cycle.
- Header 00 00 → DONE with no mem_write pulse.
- Header 01 01 (N=257, DEPTH=256) → error=1, no writes, byte_ready=0; a later start with header 01 00 loads normally and clears error.
- rst asserted after 2 bytes of word 1 (word 0 already written) → next cycle IDLE, all outputs at reset values, no further writes; restart then loads from BASE_ADDR.
- start pulsed during LOAD → ignored, load completes unchanged; with BASE_ADDR=0x100, the first write goes to mem_addr=0x100.
